// File: rtl/writeback_unit.sv
// Writeback stage: selects ALU or load data, drives the register-file write port and
// stalls upstream while a load response is outstanding. WRITEBACK_FORWARD_EN adds bypass outputs.
module writeback_unit #(
    parameter int WORD_WIDTH           = 32,
    parameter int REGISTER_INDEX_WIDTH = 5,
    parameter int LOAD_TIMEOUT         = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic                            cu_mem_to_reg_in,
    input  logic                            cu_reg_write_in,
    input  logic [REGISTER_INDEX_WIDTH-1:0] destination_register_in,
    input  logic [WORD_WIDTH-1:0]           alu_result_in,
    input  logic                            mem_data_valid_in,
    input  logic [WORD_WIDTH-1:0]           mem_data_in,
    output logic                            stall_out,
    output logic                            rf_write_enable_out,
    output logic [REGISTER_INDEX_WIDTH-1:0] rf_write_register_out,
    output logic [WORD_WIDTH-1:0]           rf_write_data_out,
    output logic                            retired_out,
    output logic                            timeout_error_out
`ifdef WRITEBACK_FORWARD_EN
    ,
    output logic                            fwd_valid_out,
    output logic [REGISTER_INDEX_WIDTH-1:0] fwd_register_out,
    output logic [WORD_WIDTH-1:0]           fwd_data_out
`endif
);

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    localparam logic [7:0] TIMEOUT_COUNT = 8'(LOAD_TIMEOUT);

    state_t                          state_q, state_d;
    logic [7:0]                      waitCount_q, waitCount_d;
    logic [REGISTER_INDEX_WIDTH-1:0] pendingDest_q, pendingDest_d;
    logic                            pendingRegWrite_q, pendingRegWrite_d;
    logic                            writeEnable_q, writeEnable_d;
    logic [REGISTER_INDEX_WIDTH-1:0] writeRegister_q, writeRegister_d;
    logic [WORD_WIDTH-1:0]           writeData_q, writeData_d;
    logic                            retired_q, retired_d;
    logic                            timeoutError_q, timeoutError_d;

    always_comb begin
        state_d           = state_q;
        waitCount_d       = waitCount_q;
        pendingDest_d     = pendingDest_q;
        pendingRegWrite_d = pendingRegWrite_q;
        writeEnable_d     = 1'b0;
        writeRegister_d   = writeRegister_q;
        writeData_d       = writeData_q;
        retired_d         = 1'b0;
        timeoutError_d    = timeoutError_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!cu_mem_to_reg_in || mem_data_valid_in) begin
                        writeEnable_d   = cu_reg_write_in && (destination_register_in != '0);
                        writeRegister_d = destination_register_in;
                        writeData_d     = cu_mem_to_reg_in ? mem_data_in : alu_result_in;
                        retired_d       = 1'b1;
                    end else begin
                        pendingDest_d     = destination_register_in;
                        pendingRegWrite_d = cu_reg_write_in;
                        waitCount_d       = 8'd1;
                        state_d           = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                // Arriving data beats the timeout even on the final counted cycle.
                if (mem_data_valid_in) begin
                    writeEnable_d   = pendingRegWrite_q && (pendingDest_q != '0);
                    writeRegister_d = pendingDest_q;
                    writeData_d     = mem_data_in;
                    retired_d       = 1'b1;
                    waitCount_d     = 8'd0;
                    state_d         = IDLE;
                end else if (waitCount_q == TIMEOUT_COUNT) begin
                    timeoutError_d = 1'b1;
                    waitCount_d    = 8'd0;
                    state_d        = IDLE;
                end else begin
                    waitCount_d = waitCount_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            waitCount_q       <= 8'd0;
            pendingDest_q     <= '0;
            pendingRegWrite_q <= 1'b0;
            writeEnable_q     <= 1'b0;
            writeRegister_q   <= '0;
            writeData_q       <= '0;
            retired_q         <= 1'b0;
            timeoutError_q    <= 1'b0;
        end else begin
            state_q           <= state_d;
            waitCount_q       <= waitCount_d;
            pendingDest_q     <= pendingDest_d;
            pendingRegWrite_q <= pendingRegWrite_d;
            writeEnable_q     <= writeEnable_d;
            writeRegister_q   <= writeRegister_d;
            writeData_q       <= writeData_d;
            retired_q         <= retired_d;
            timeoutError_q    <= timeoutError_d;
        end
    end

    assign stall_out             = (state_q == WAIT_MEM);
    assign rf_write_enable_out   = writeEnable_q;
    assign rf_write_register_out = writeRegister_q;
    assign rf_write_data_out     = writeData_q;
    assign retired_out           = retired_q;
    assign timeout_error_out     = timeoutError_q;

`ifdef WRITEBACK_FORWARD_EN
    // Bypass sees the completion one cycle early; qualified by the write strobe only.
    assign fwd_valid_out    = writeEnable_d;
    assign fwd_register_out = writeRegister_d;
    assign fwd_data_out     = writeData_d;
`endif

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writeback stage. Consumes the MEM/WB pipeline-register outputs (control bits, destination index, ALU result) and the data-memory load response.
- Selects the writeback value, drives the register-file write port and stalls the pipeline while a load response is outstanding.
- Sits between the MEM/WB register and the register file. It is the reading end of the MEM/WB interface.

Parameters:
- WORD_WIDTH, 32, datapath width
- REGISTER_INDEX_WIDTH, 5, register index width
- LOAD_TIMEOUT, 16, max cycles in WAIT_MEM before the load is abandoned (legal range 2..255)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  MEM/WB entry holds a real instruction (0 = bubble)
- cu_mem_to_reg_in  in  1  1 = writeback value comes from memory load
- cu_reg_write_in  in  1  instruction writes a register
- destination_register_in  in  REGISTER_INDEX_WIDTH  destination index
- alu_result_in  in  WORD_WIDTH  ALU result
- mem_data_valid_in  in  1  load data valid this cycle
- mem_data_in  in  WORD_WIDTH  load data
- stall_out  out  1  hold MEM/WB and earlier stages
- rf_write_enable_out  out  1  register-file write strobe
- rf_write_register_out  out  REGISTER_INDEX_WIDTH  write index
- rf_write_data_out  out  WORD_WIDTH  write data
- retired_out  out  1  one-cycle pulse per completed instruction
- timeout_error_out  out  1  sticky: a load was abandoned

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0, latched destination and control 0. Reset asserted mid-WAIT_MEM drops the pending load with no write and no retire.
- States: IDLE, WAIT_MEM. stall_out = (state == WAIT_MEM), decoded from registered state only.
- All rf_* outputs and retired_out are registered. A completing instruction drives them in the cycle after completion. rf_write_enable_out and retired_out are otherwise 0.
- IDLE with in_valid=0: no action.
- IDLE, in_valid=1, cu_mem_to_reg_in=0:
  - completes immediately (latency 1)
  - write strobe = cu_reg_write_in AND (destination != 0)
  - data = alu_result_in
  - retired_out=1
- IDLE, in_valid=1, cu_mem_to_reg_in=1, mem_data_valid_in=1 in the same cycle: completes immediately as above, using mem_data_in.
- IDLE, in_valid=1, cu_mem_to_reg_in=1, mem_data_valid_in=0:
  - latch destination and cu_reg_write_in
  - go to WAIT_MEM; counter loads 1
- WAIT_MEM:
  - in_valid and all *_in control/data are ignored; upstream holds them because of stall.
  - mem_data_valid_in=1: complete using mem_data_in and the latched destination/write flag. Return to IDLE. stall_out falls the same edge that the write outputs rise.
  - No data: counter increments. At counter == LOAD_TIMEOUT with no data: return to IDLE, no write, retired_out=0, set timeout_error_out. timeout_error_out clears only on rst.
  - mem_data_valid_in in the same cycle the counter reaches LOAD_TIMEOUT: data wins, normal completion, no error.
- mem_data_valid_in while IDLE with no load being accepted: ignored.
- Register 0 is never written, but a valid instruction targeting it still retires.
- mem_to_reg with reg_write=0: still waits for data (or times out), retires, no write.
- Back-to-back non-load instructions: one completion per cycle, no stall.

Optional Feature:
- Macro: WRITEBACK_FORWARD_EN
- Enabled: adds outputs fwd_valid_out (1), fwd_register_out (REGISTER_INDEX_WIDTH) and fwd_data_out (WORD_WIDTH). They are combinational copies of the value that will appear on rf_* next cycle, i.e. the completion computed this cycle, for same-cycle bypass to the execute stage. fwd_valid_out=0 whenever the next-cycle write strobe is 0.
- Disabled: these ports do not exist; no other behaviour changes.

Test Plan:
- Reset → all outputs 0. Then ALU op: in_valid=1, reg_write=1, mem_to_reg=0, dest=5, alu=0x1234 → next cycle write strobe=1, reg=5, data=0x1234, retired=1, stall=0.
- Load with data 3 cycles later (0xCAFEBABE, dest=7) → stall_out high for 3 cycles. Cycle after data: write reg 7 = 0xCAFEBABE, retired=1, stall=0.
- Load with mem_data_valid_in in the same cycle as in_valid → no stall; next cycle write with mem data.
- ALU op with dest=0, reg_write=1 → rf_write_enable_out=0, retired_out=1.
- Load never answered, LOAD_TIMEOUT=4 → stall for 4 cycles, then IDLE, no write, timeout_error_out=1 and held until rst. Repeat with data arriving exactly at the 4th cycle → normal write, error stays 0.
- rst asserted during WAIT_MEM, data arrives the following cycle → no write, no retire, stall_out=0 after the reset edge.
